operand_bypass_unit: RTL

//  Execute-stage consumer of forwarding_unit selects (rs1_src/rs2_src/busy/invalid).

---
 rtl/rv_fwd_pkg.sv | 37 +++
 rtl/bypass_mux.sv | 26 ++
 rtl/operand_bypass_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rv_fwd_pkg.sv
// Shared forwarding definitions: operand source codes, bypass FSM states and
// opcode constants common to forwarding_unit and operand_bypass_unit.
package rv_fwd_pkg;

    localparam logic [1:0] SRC_REG  = 2'd0;
    localparam logic [1:0] SRC_ALU1 = 2'd1;
    localparam logic [1:0] SRC_ALU2 = 2'd2;
    localparam logic [1:0] SRC_MEM  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_REPLAY = 2'd2
    } bypass_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Number of non-register operand selections in one issued instruction;
    // rs2 does not count when the immediate replaces it.
    function automatic logic [1:0] fwd_incr(input logic [1:0] rs1_src,
                                            input logic [1:0] rs2_src,
                                            input logic       invalid);
        logic [1:0] n;
        n = {1'b0, rs1_src != SRC_REG};
        n = n + {1'b0, (rs2_src != SRC_REG) && !invalid};
        return n;
    endfunction

endpackage

// File: rtl/bypass_mux.sv
// Combinational 4:1 operand select driven by a forwarding source code.
module bypass_mux
    import rv_fwd_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      src,
    input  logic [XLEN-1:0] rf_data,
    input  logic [XLEN-1:0] hist1,
    input  logic [XLEN-1:0] hist2,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = rf_data;
        case (src)
            SRC_REG:  y = rf_data;
            SRC_ALU1: y = hist1;
            SRC_ALU2: y = hist2;
            SRC_MEM:  y = mem_data;
            default:  y = rf_data;
        endcase
    end

endmodule

// File: rtl/operand_bypass_unit.sv
// Execute-stage operand registers fed from RF, ALU history or load data, with load-use
// stall/replay sequencing. Define BYPASS_STATS_EN to add the fwd_count/stall_count counters.
module operand_bypass_unit
    import rv_fwd_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MAX_STALL = 8
`ifdef BYPASS_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic            clk,
    input  logic            reset2,
    input  logic [1:0]      rs1_src,
    input  logic [1:0]      rs2_src,
    input  logic            busy,
    input  logic            invalid,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_valid,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic            op_valid,
    output logic            stall,
    output logic            stall_err
`ifdef BYPASS_STATS_EN
    ,
    output logic [CNT_W-1:0] fwd_count,
    output logic [CNT_W-1:0] stall_count
`endif
);

    localparam int TMR_W = $clog2(MAX_STALL) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MAX_STALL - 1);

    bypass_state_e   state, state_nxt;
    logic [XLEN-1:0] hist1, hist2, load_q;
    logic [XLEN-1:0] mem_data, a_sel, b_sel, b_fin;
    logic [TMR_W-1:0] timer;
    logic            issue, timeout;

    // A replayed instruction consumes the captured load, not whatever is on the bus now.
    assign mem_data = (state == ST_REPLAY) ? load_q : load_data;

    bypass_mux #(.XLEN(XLEN)) u_mux_a (
        .src      (rs1_src),
        .rf_data  (rf_rs1_data),
        .hist1    (hist1),
        .hist2    (hist2),
        .mem_data (mem_data),
        .y        (a_sel)
    );

    bypass_mux #(.XLEN(XLEN)) u_mux_b (
        .src      (rs2_src),
        .rf_data  (rf_rs2_data),
        .hist1    (hist1),
        .hist2    (hist2),
        .mem_data (mem_data),
        .y        (b_sel)
    );

    assign b_fin = invalid ? imm : b_sel;
    assign stall = (state == ST_STALL);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_RUN: begin
                issue = !busy;
                if (busy)
                    state_nxt = ST_STALL;
            end
            ST_STALL: begin
                // load_valid beats the timeout on the same cycle
                if (load_valid) begin
                    state_nxt = ST_REPLAY;
                end else if (timer == TMR_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_REPLAY: begin
                issue     = 1'b1;
                state_nxt = busy ? ST_STALL : ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset2) begin
        if (!reset2) begin
            state     <= ST_RUN;
            op_a      <= '0;
            op_b      <= '0;
            op_valid  <= 1'b0;
            stall_err <= 1'b0;
            hist1     <= '0;
            hist2     <= '0;
            load_q    <= '0;
            timer     <= '0;
        end else begin
            state     <= state_nxt;
            op_valid  <= issue;
            stall_err <= timeout;
            if (issue) begin
                op_a <= a_sel;
                op_b <= b_fin;
            end
            // History freezes while stalled so the replayed selects still line up.
            if (state != ST_STALL) begin
                hist2 <= hist1;
                hist1 <= alu_result;
            end
            if (state == ST_STALL && load_valid)
                load_q <= load_data;
            timer <= (state == ST_STALL) ? timer + 1'b1 : '0;
        end
    end

`ifdef BYPASS_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       fwd_inc;
    logic [CNT_W+1:0] fwd_sum;

    assign fwd_inc = issue ? fwd_incr(rs1_src, rs2_src, invalid) : 2'd0;
    assign fwd_sum = {2'b00, fwd_count} + {{CNT_W{1'b0}}, fwd_inc};

    always_ff @(posedge clk or negedge reset2) begin
        if (!reset2) begin
            fwd_count   <= '0;
            stall_count <= '0;
        end else begin
            fwd_count <= (fwd_sum > {2'b00, CNT_MAX}) ? CNT_MAX : fwd_sum[CNT_W-1:0];
            if (state == ST_STALL && stall_count != CNT_MAX)
                stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule
